// File: rtl/fp32_uart_tx.sv
// 8N1 UART transmitter for one NUM_BYTES-wide word, byte 0 first, each byte LSB first.
// Define FP32_UART_TX_GUARD_EN to add a second idle-high bit period (GUARD) after every stop bit.
module fp32_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 4
) (
    input  logic                   CLK_I,
    input  logic                   RSTL_I,
    input  logic                   TX_VALID_I,
    output logic                   TX_READY_O,
    input  logic [8*NUM_BYTES-1:0] TX_DATA_I,
    output logic                   UART_TX_O,
    output logic                   TX_DONE_O
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
`ifdef FP32_UART_TX_GUARD_EN
        ST_GUARD = 3'd4,
`endif
        ST_STOP  = 3'd3
    } state_t;

    state_t                 r_state;
    logic [8*NUM_BYTES-1:0] r_shift;
    logic [CW-1:0]          r_clk_cnt;
    logic [2:0]             r_bit_idx;
    logic [BW-1:0]          r_byte_idx;
    logic                   r_tx;
    logic                   r_ready;
    logic                   r_done;

    logic w_bit_end;
    logic w_last_byte;

    assign w_bit_end   = (r_clk_cnt == CNT_MAX);
    assign w_last_byte = (r_byte_idx == LAST_BYTE);

    assign UART_TX_O  = r_tx;
    assign TX_READY_O = r_ready;
    assign TX_DONE_O  = r_done;

    // The line value is set on the edge that enters each bit, so UART_TX_O is a plain flop.
    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx       <= 1'b1;
                    r_ready    <= 1'b1;
                    r_clk_cnt  <= '0;
                    r_bit_idx  <= '0;
                    r_byte_idx <= '0;
                    if (TX_VALID_I && r_ready) begin
                        r_shift <= TX_DATA_I;
                        r_tx    <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_shift   <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
`ifdef FP32_UART_TX_GUARD_EN
                        r_state   <= ST_GUARD;
`else
                        if (w_last_byte) begin
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= ST_START;
                        end
`endif
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`ifdef FP32_UART_TX_GUARD_EN
                ST_GUARD: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (w_last_byte) begin
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= ST_START;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_uart_tx.sv
// Randomised + directed bench for fp32_uart_tx against a cycle-indexed frame model.
module tb_fp32_uart_tx;

    localparam int CPB = 4;
    localparam int NB  = 4;
`ifdef FP32_UART_TX_GUARD_EN
    localparam int G        = 1;
    localparam int DONE_LIT = 176;
`else
    localparam int G        = 0;
    localparam int DONE_LIT = 160;
`endif
    localparam int F = NB * (10 + G) * CPB;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data  = '0;
    logic        ready;
    logic        tx;
    logic        done;

    always #5 clk = ~clk;

    fp32_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
        .CLK_I      (clk),
        .RSTL_I     (rst_n),
        .TX_VALID_I (valid),
        .TX_READY_O (ready),
        .TX_DATA_I  (data),
        .UART_TX_O  (tx),
        .TX_DONE_O  (done)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    bit          m_busy      = 1'b0;
    bit          m_done      = 1'b0;
    int          m_start     = 0;
    logic [31:0] m_word      = '0;
    bit          m_hs;
    bit          chk_en      = 1'b0;
    logic        c_tx, c_rdy, c_done;

    // Model: a frame is a fixed bit timeline starting at the accepting edge.
    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
        end else begin
            m_hs = valid && !m_busy;
            if (m_busy && cyc == m_start + F) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
            if (m_hs) begin
                m_busy  = 1'b1;
                m_start = cyc;
                m_word  = data;
            end
        end
    end

    function automatic logic exp_tx();
        int off, bp, bt, sl;
        if (!m_busy) return 1'b1;
        off = cyc - m_start;
        bp  = off / CPB;
        bt  = bp / (10 + G);
        sl  = bp % (10 + G);
        if (sl == 0) return 1'b0;
        if (sl <= 8) return m_word[8*bt + sl - 1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                c_tx = 1'b1; c_rdy = 1'b1; c_done = 1'b0;
            end else begin
                c_tx = exp_tx(); c_rdy = !m_busy; c_done = m_done;
            end
            vectors++;
            if (tx !== c_tx || ready !== c_rdy || done !== c_done) begin
                miscompares++;
                if (miscompares <= 40)
                    $display("FAIL cycle %0d: tx/ready/done got %b%b%b expected %b%b%b",
                             cyc, tx, ready, done, c_tx, c_rdy, c_done);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [31:0] w);
        valid = 1'b1;
        data  = w;
        tick();
        valid = 1'b0;
        data  = $urandom;
    endtask

    // Samples the line mid-bit independently of the model; returns word and done offset.
    task automatic decode(output logic [31:0] w, output int done_at);
        int bp, bt, sl;
        w = '0;
        done_at = -1;
        for (int k = 0; k < F + 4; k++) begin
            @(negedge clk);
            bp = k / CPB;
            bt = bp / (10 + G);
            sl = bp % (10 + G);
            if (bt < NB && (k % CPB) == CPB / 2 && sl >= 1 && sl <= 8)
                w[8*bt + sl - 1] = tx;
            if (done === 1'b1 && done_at < 0) done_at = k;
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] got_w;
    int          got_d;
    bit          seen;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        repeat (100) tick();
        check("idle_tx", {31'd0, tx}, 32'd1);

        send_word(32'h3F80_0000);
        decode(got_w, got_d);
        check("one_word", got_w, 32'h3F80_0000);
        check("one_byte2", {24'd0, got_w[23:16]}, 32'h80);
        check("one_done_at", got_d, DONE_LIT);

        send_word(32'h40490FDB);
        repeat (40) tick();
        check("busy_ready", {31'd0, ready}, 32'd0);
        data  = 32'hFFFF_FFFF;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("busy_ready_after", {31'd0, ready}, 32'd0);
        repeat (F + 10) tick();
        check("no_second_frame", {31'd0, ready}, 32'd1);

        valid = 1'b1;
        data  = 32'hA5A5_A5A5;
        for (int f = 0; f < 2; f++) begin
            seen = 1'b0;
            for (int k = 0; k < F + 10 && !seen; k++) begin
                @(negedge clk);
                if (done === 1'b1) seen = 1'b1;
            end
            check("b2b_done_seen", {31'd0, seen}, 32'd1);
            check("b2b_gap_tx", {31'd0, tx}, 32'd1);
            @(negedge clk);
            check("b2b_next_start", {31'd0, tx}, 32'd0);
            check("b2b_next_busy", {31'd0, ready}, 32'd0);
        end
        tick();
        valid = 1'b0;
        repeat (F + 10) tick();

        send_word(32'hDEAD_BEEF);
        repeat ((2 * (10 + G) + 2) * CPB + 1) tick();
        check("pre_rst_tx", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_ready", {31'd0, ready}, 32'd1);
        check("async_rst_done", {31'd0, done}, 32'd0);
        #1;
        repeat (3) tick();
        rst_n = 1'b1;
        send_word(32'h1234_5678);
        decode(got_w, got_d);
        check("post_rst_word", got_w, 32'h1234_5678);
        check("post_rst_done_at", got_d, DONE_LIT);

        repeat (3000) begin
            valid = ($urandom_range(0, 7) == 0);
            data  = $urandom;
            tick();
        end
        valid = 1'b0;
        repeat (F + 10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp32_uart_tx.md
# fp32_uart_tx

UART transmitter that serialises one FP32 result word (default 4 bytes) onto the host-bound TX line, LSB byte first, 8N1 framing. It is the outbound end of the rx → MAC → tx path: it accepts a word from the MAC via a valid/ready handshake, then streams it at a fixed bit period to the host. The fp32 UART receiver on the other side of the link expects this byte and bit ordering.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal ≥ 2
- NUM_BYTES, 4, bytes per transmitted word; data width = 8*NUM_BYTES
- CLK_I  input  1  system clock, all logic on rising edge
- RSTL_I  input  1  reset; one clock, reset asynchronous and active-low
- TX_VALID_I  input  1  word on TX_DATA_I is valid
- TX_READY_O  output  1  block idle, will accept a word this cycle
- TX_DATA_I  input  8*NUM_BYTES  word to send; byte k = bits [8k+7:8k]
- UART_TX_O  output  1  serial line, idle high
- TX_DONE_O  output  1  one-cycle pulse: last frame bit finished

## Operation
- Reset values: UART_TX_O=1, TX_READY_O=1, TX_DONE_O=0; state IDLE, all counters 0.
- Registers: shift register (8*NUM_BYTES), clk_cnt (0..CLKS_PER_BIT-1), bit_idx (0..7), byte_idx (0..NUM_BYTES-1).
- Handshake: transfer occurs on a rising edge where TX_VALID_I && TX_READY_O. TX_DATA_I is captured into the shift register; afterwards TX_DATA_I may change freely.
- TX_READY_O is 1 only in IDLE. TX_VALID_I while busy is ignored (no queueing).
- States:
  - IDLE: UART_TX_O=1; on handshake → START, clk_cnt=0.
  - START: UART_TX_O=0 for CLKS_PER_BIT cycles → DATA, bit_idx=0.
  - DATA: UART_TX_O = shift[0]; after CLKS_PER_BIT cycles shift right by 1; if bit_idx==7 → STOP, else bit_idx+1.
  - STOP: UART_TX_O=1 for CLKS_PER_BIT cycles; then GUARD if macro defined, else: if byte_idx==NUM_BYTES-1 → IDLE, else byte_idx+1 → START.
  - GUARD (macro only): UART_TX_O=1 for CLKS_PER_BIT cycles; then same byte-end decision as STOP.
  - Illegal state encoding → IDLE, UART_TX_O=1.
- Bit order: byte 0 first, each byte LSB first; bit n of the word is the n-th data bit on the line.
- UART_TX_O is registered (no combinational glitches).

## Timing
- Start bit begins at the edge after the handshake edge; line stays low exactly CLKS_PER_BIT cycles.
- Per byte: (10 + G) * CLKS_PER_BIT cycles, G=1 with macro, 0 without.
- Frame: NUM_BYTES*(10+G)*CLKS_PER_BIT cycles from start-bit first cycle to return to IDLE.
- On the edge leaving the final stop/guard bit: state=IDLE, TX_READY_O=1, TX_DONE_O=1 for exactly that one cycle.
- Back-to-back: TX_VALID_I held high → accepted in the TX_DONE_O cycle; next start bit follows; minimum inter-frame idle = 1 clock.
- Reset asserted mid-frame: frame aborted immediately (async), UART_TX_O=1, TX_READY_O=1, TX_DONE_O=0; no partial resume after release.
- TX_VALID_I in the same cycle reset releases: not accepted until first rising edge with RSTL_I high.

## Configuration
- FP32_UART_TX_GUARD_EN defined: one extra idle-high bit period (GUARD state) after each byte's stop bit, i.e. 2 stop bits; required when driving the fp32 UART receiver, which spends one extra bit period after each stop bit before re-arming start detection.
- Undefined: standard 8N1, one stop bit, GUARD state absent; byte time 10 bit periods.

## Test plan
- Reset then idle, CLKS_PER_BIT=4, no valid → UART_TX_O=1, TX_READY_O=1, TX_DONE_O=0 for 100 cycles.
- Send 0x3F800000 (1.0), macro off, CLKS_PER_BIT=4 → line decodes bytes 0x00,0x00,0x80,0x3F LSB-first; TX_DONE_O pulse exactly 160 cycles after start-bit first cycle.
- Same with FP32_UART_TX_GUARD_EN → 2 high bit periods between bytes; TX_DONE_O at 176 cycles; loopback into fp32 UART receiver (12-byte mode, 3 words 0x40490FDB, 0xC0000000, 0x00000001) yields exact 96-bit RX_DATA_O.
- TX_DATA_I changed to 0xFFFFFFFF and TX_VALID_I pulsed mid-frame → transmitted bits unchanged, TX_READY_O stays 0, no second frame.
- TX_VALID_I held high with 0xA5A5A5A5 → consecutive frames with exactly 1 idle-high clock between final stop bit and next start bit.
- RSTL_I low during byte 2 data bits → UART_TX_O=1 same cycle (async), TX_READY_O=1; after release, new word 0x12345678 sent correctly.
